audio_filter_sched: RTL and testbench

AUDIO_FILTER_SCHED -- requirements
Module: audio_filter_sched

---
 rtl/audio_pkg.sv | 50 +++++
 rtl/audio_mac.sv | 33 +++
 rtl/audio_filter_sched.sv | 204 ++++++++++++++++++++
 tb/tb_audio_filter_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and helpers for the time-shared biquad scheduler.
package audio_pkg;

    localparam int unsigned ACC_W     = 40;
    localparam int unsigned MAC_STEPS = 5;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMac,
        StWb,
        StOut
    } state_e;

    typedef logic stage_t;   // 0: stage 0, 1: stage 1
    typedef logic chan_t;    // 0: left, 1: right

    // Per-(stage, channel) history slot; low two bits of the register-file address.
    typedef enum logic [1:0] {
        SlotX1 = 2'd0,
        SlotX2 = 2'd1,
        SlotY1 = 2'd2,
        SlotY2 = 2'd3
    } slot_e;

    typedef logic [3:0] hist_addr_t;

    typedef struct packed {
        logic   found;
        stage_t stage;
        chan_t  chan;
    } pair_t;

    function automatic hist_addr_t hist_addr(stage_t s, chan_t c, slot_e k);
        return {s, c, k};
    endfunction

    // First enabled pair at or after position 'start' in the order S0L, S0R, S1L, S1R.
    // Later assignments win, so the lowest qualifying position is returned.
    function automatic pair_t next_pair(logic [1:0] en, logic [2:0] start);
        pair_t p;
        p = '0;
        if (en[1] && start <= 3'd3) p = '{found: 1'b1, stage: 1'b1, chan: 1'b1};
        if (en[1] && start <= 3'd2) p = '{found: 1'b1, stage: 1'b1, chan: 1'b0};
        if (en[0] && start <= 3'd1) p = '{found: 1'b1, stage: 1'b0, chan: 1'b1};
        if (en[0] && start == 3'd0) p = '{found: 1'b1, stage: 1'b0, chan: 1'b0};
        return p;
    endfunction

endpackage

// File: rtl/audio_mac.sv
// audio_mac: one signed COEF_W x 16 multiplier feeding a 40-bit accumulator.
module audio_mac
    import audio_pkg::*;
#(
    parameter int unsigned COEF_W = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [15:0]       data,
    input  logic                     clr,
    input  logic                     en,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [COEF_W+15:0] prod;
    logic signed [ACC_W-1:0]   acc_q;

    assign prod = (COEF_W + 16)'(coef) * (COEF_W + 16)'(data);
    assign acc  = acc_q;

    // Accumulator: clear has priority over accumulate.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/audio_filter_sched.sv
// audio_filter_sched: stereo two-stage biquad cascade sharing one MAC.
// Config macro: AUDIO_FILTER_SAT_EN -- saturate stage outputs to 16 bits (default: wrap).
// Each enabled (stage, channel) pair costs 6 cycles: 5 MAC cycles plus one WB cycle
// that also makes the next-pair decision, so a sample takes 2 + 12*N cycles.
module audio_filter_sched
    import audio_pkg::*;
#(
    parameter int unsigned              COEF_W = 18,
    parameter logic signed [COEF_W-1:0] S0_B0  = '0,
    parameter logic signed [COEF_W-1:0] S0_B1  = '0,
    parameter logic signed [COEF_W-1:0] S0_B2  = '0,
    parameter logic signed [COEF_W-1:0] S0_NA1 = '0,
    parameter logic signed [COEF_W-1:0] S0_NA2 = '0,
    parameter logic signed [COEF_W-1:0] S1_B0  = '0,
    parameter logic signed [COEF_W-1:0] S1_B1  = '0,
    parameter logic signed [COEF_W-1:0] S1_B2  = '0,
    parameter logic signed [COEF_W-1:0] S1_NA1 = '0,
    parameter logic signed [COEF_W-1:0] S1_NA2 = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_ce,
    input  logic signed [15:0] in_l,
    input  logic signed [15:0] in_r,
    input  logic [1:0]         en,
    output logic signed [15:0] out_l,
    output logic signed [15:0] out_r,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    localparam logic signed [ACC_W-1:0] YMax = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] YMin = -ACC_W'(32768);

    state_e             state_q;
    logic [2:0]         step_q;
    stage_t             stage_q;
    chan_t              chan_q;
    logic [1:0]         en_q;
    // Per-channel working sample: the input, then each enabled stage's output in turn.
    logic signed [15:0] cur_q  [2];
    logic signed [15:0] hist_q [16];

    logic signed [COEF_W-1:0] coef;
    logic signed [15:0]       data;
    logic                     mac_clr;
    logic                     mac_en;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  y_full;
    logic signed [15:0]       y16;
    logic [2:0]               start;
    pair_t                    nxt;

    assign mac_en  = (state_q == StMac);
    assign mac_clr = (state_q == StLoad) || (state_q == StWb);
    assign y_full  = acc >>> (COEF_W - 2);

    audio_mac #(
        .COEF_W (COEF_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .coef  (coef),
        .data  (data),
        .clr   (mac_clr),
        .en    (mac_en),
        .acc   (acc)
    );

    // Operand select for the current MAC step: b0*x, b1*x1, b2*x2, na1*y1, na2*y2.
    always_comb begin
        coef = '0;
        data = '0;
        case (step_q)
            3'd0: begin
                coef = stage_q ? S1_B0 : S0_B0;
                data = cur_q[chan_q];
            end
            3'd1: begin
                coef = stage_q ? S1_B1 : S0_B1;
                data = hist_q[hist_addr(stage_q, chan_q, SlotX1)];
            end
            3'd2: begin
                coef = stage_q ? S1_B2 : S0_B2;
                data = hist_q[hist_addr(stage_q, chan_q, SlotX2)];
            end
            3'd3: begin
                coef = stage_q ? S1_NA1 : S0_NA1;
                data = hist_q[hist_addr(stage_q, chan_q, SlotY1)];
            end
            3'd4: begin
                coef = stage_q ? S1_NA2 : S0_NA2;
                data = hist_q[hist_addr(stage_q, chan_q, SlotY2)];
            end
            default: ;
        endcase
    end

    // Reduce the scaled accumulator to a 16-bit stage output.
    always_comb begin
`ifdef AUDIO_FILTER_SAT_EN
        if (y_full > YMax) begin
            y16 = 16'sh7fff;
        end else if (y_full < YMin) begin
            y16 = 16'sh8000;
        end else begin
            y16 = 16'(y_full);
        end
`else
        y16 = 16'(y_full);
`endif
    end

    // Next enabled pair: from the start after a new sample, else after the pair just written.
    always_comb begin
        start = 3'd0;
        if (state_q == StWb) begin
            start = {1'b0, stage_q, chan_q} + 3'd1;
        end
        nxt = next_pair(en_q, start);
    end

    // Sequencer, history register file and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            step_q    <= '0;
            stage_q   <= 1'b0;
            chan_q    <= 1'b0;
            en_q      <= '0;
            cur_q[0]  <= '0;
            cur_q[1]  <= '0;
            for (int i = 0; i < 16; i++) begin
                hist_q[i] <= '0;
            end
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            // A sample arriving while one is in flight is dropped, OUT cycle included.
            if (sample_ce && state_q != StIdle) begin
                overrun <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (sample_ce) begin
                        cur_q[0] <= in_l;
                        cur_q[1] <= in_r;
                        en_q     <= en;
                        busy     <= 1'b1;
                        state_q  <= StLoad;
                    end
                end
                StLoad: begin
                    step_q <= '0;
                    if (nxt.found) begin
                        stage_q <= nxt.stage;
                        chan_q  <= nxt.chan;
                        state_q <= StMac;
                    end else begin
                        state_q <= StOut;
                    end
                end
                StMac: begin
                    if (step_q == 3'(MAC_STEPS - 1)) begin
                        state_q <= StWb;
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                StWb: begin
                    hist_q[hist_addr(stage_q, chan_q, SlotX2)] <=
                        hist_q[hist_addr(stage_q, chan_q, SlotX1)];
                    hist_q[hist_addr(stage_q, chan_q, SlotX1)] <= cur_q[chan_q];
                    hist_q[hist_addr(stage_q, chan_q, SlotY2)] <=
                        hist_q[hist_addr(stage_q, chan_q, SlotY1)];
                    hist_q[hist_addr(stage_q, chan_q, SlotY1)] <= y16;
                    cur_q[chan_q] <= y16;
                    step_q        <= '0;
                    if (nxt.found) begin
                        stage_q <= nxt.stage;
                        chan_q  <= nxt.chan;
                        state_q <= StMac;
                    end else begin
                        state_q <= StOut;
                    end
                end
                StOut: begin
                    out_l     <= cur_q[0];
                    out_r     <= cur_q[1];
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_filter_sched.sv
// Bench for audio_filter_sched: three instances with different coefficient sets.
//   inst 0: S0 = unity + near-integrator feedback, S1 = unity
//   inst 1: S0 = unity, S1 = half gain (feed-forward only, no memory)
//   inst 2: S0 = b0 + b1 both unity, so two equal samples give gain 2
module tb_audio_filter_sched;

    logic               clk = 1'b0;
    logic               reset;
    logic               ce   [3];
    logic signed [15:0] il   [3];
    logic signed [15:0] ir   [3];
    logic [1:0]         ena  [3];
    logic signed [15:0] ol   [3];
    logic signed [15:0] orr  [3];
    logic               ov   [3];
    logic               bsy  [3];
    logic               ovr  [3];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int pulse_cnt [3];

    typedef struct {
        int inst;
        int l;
        int r;
        int lat;
        int acc_cyc;
    } exp_t;

    exp_t sb [$];
    exp_t cur_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    audio_filter_sched #(
        .COEF_W (18),
        .S0_B0  (18'sd65536),
        .S0_NA1 (18'sd65535),
        .S1_B0  (18'sd65536)
    ) dut0 (
        .clk (clk), .reset (reset), .sample_ce (ce[0]), .in_l (il[0]), .in_r (ir[0]),
        .en (ena[0]), .out_l (ol[0]), .out_r (orr[0]), .out_valid (ov[0]), .busy (bsy[0]),
        .overrun (ovr[0])
    );

    audio_filter_sched #(
        .COEF_W (18),
        .S0_B0  (18'sd65536),
        .S1_B0  (18'sd32768)
    ) dut1 (
        .clk (clk), .reset (reset), .sample_ce (ce[1]), .in_l (il[1]), .in_r (ir[1]),
        .en (ena[1]), .out_l (ol[1]), .out_r (orr[1]), .out_valid (ov[1]), .busy (bsy[1]),
        .overrun (ovr[1])
    );

    audio_filter_sched #(
        .COEF_W (18),
        .S0_B0  (18'sd65536),
        .S0_B1  (18'sd65536)
    ) dut2 (
        .clk (clk), .reset (reset), .sample_ce (ce[2]), .in_l (il[2]), .in_r (ir[2]),
        .en (ena[2]), .out_l (ol[2]), .out_r (orr[2]), .out_valid (ov[2]), .busy (bsy[2]),
        .overrun (ovr[2])
    );

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Scoreboard consumer: every out_valid must match the oldest pending expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ov[i]) begin
                pulse_cnt[i]++;
                if (sb.size() == 0 || sb[0].inst != i) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_out_valid: inst %0d cycle %0d out_l=%0d, required no pulse",
                             i, cyc, ol[i]);
                end else begin
                    cur_exp = sb.pop_front();
                    check("out_l", int'(ol[i]), cur_exp.l);
                    check("out_r", int'(orr[i]), cur_exp.r);
                    check("latency", cyc - cur_exp.acc_cyc, cur_exp.lat);
                    check("busy_at_valid", int'(bsy[i]), 0);
                end
            end
        end
    end

    // Drive one sample_ce pulse; returns at the negedge just after it was sampled.
    task automatic send(input int i, input logic [1:0] e, input int l, input int r,
                        input bit push, input int xl, input int xr, input int lat);
        @(negedge clk);
        ce[i]  = 1'b1;
        ena[i] = e;
        il[i]  = 16'(l);
        ir[i]  = 16'(r);
        @(negedge clk);
        ce[i]  = 1'b0;
        il[i]  = '0;
        ir[i]  = '0;
        if (push) sb.push_back('{inst: i, l: xl, r: xr, lat: lat, acc_cyc: cyc});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: %0d results pending, required 0", tag, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0] e;
        int l;
        int r;
        int xl;
        int xr;
        int lat;
    } vec_t;

    vec_t tbl [8];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int p0;
        int p2;
        int imp_in  [5];
        int imp_out [5];
        logic [1:0] imp_en [5];

        tbl[0] = '{e: 2'b00, l: 1000,   r: -1000,  xl: 1000,   xr: -1000,  lat: 2};
        tbl[1] = '{e: 2'b01, l: 12345,  r: -7,     xl: 12345,  xr: -7,     lat: 14};
        tbl[2] = '{e: 2'b01, l: 100,    r: 200,    xl: 100,    xr: 200,    lat: 14};
        tbl[3] = '{e: 2'b10, l: 1000,   r: -1001,  xl: 500,    xr: -501,   lat: 14};
        tbl[4] = '{e: 2'b11, l: 4000,   r: -3,     xl: 2000,   xr: -2,     lat: 26};
        tbl[5] = '{e: 2'b01, l: 32767,  r: -32768, xl: 32767,  xr: -32768, lat: 14};
        tbl[6] = '{e: 2'b11, l: -32768, r: 32767,  xl: -16384, xr: 16383,  lat: 26};
        tbl[7] = '{e: 2'b00, l: 0,      r: 1,      xl: 0,      xr: 1,      lat: 2};

        // Near-integrator impulse decays by one LSB per sample; en=10 leaves S0 history alone.
        imp_in  = '{16384, 0, 777, 0, 0};
        imp_out = '{16384, 16383, 777, 16382, 16381};
        imp_en  = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11};

        for (int i = 0; i < 3; i++) begin
            ce[i] = 1'b0; il[i] = '0; ir[i] = '0; ena[i] = '0; pulse_cnt[i] = 0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_out_l", int'(ol[i]), 0);
            check("rst_out_r", int'(orr[i]), 0);
            check("rst_out_valid", int'(ov[i]), 0);
            check("rst_busy", int'(bsy[i]), 0);
            check("rst_overrun", int'(ovr[i]), 0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Table vectors on the memoryless instance.
        for (int k = 0; k < 8; k++) begin
            send(1, tbl[k].e, tbl[k].l, tbl[k].r, 1'b1, tbl[k].xl, tbl[k].xr, tbl[k].lat);
            check("busy_after_accept", int'(bsy[1]), 1);
            drain("table");
        end
        check("overrun_clean", int'(ovr[1]), 0);

        for (int k = 0; k < 5; k++) begin
            send(0, imp_en[k], imp_in[k], 0, 1'b1, imp_out[k], 0, (imp_en[k] == 2'b11) ? 26 : 14);
            drain("impulse");
        end

        // Overrun at cycle 10; en changed mid-flight must not matter.
        p0 = pulse_cnt[0];
        send(0, 2'b11, 0, 0, 1'b1, 16380, 0, 26);
        repeat (9) @(negedge clk);
        check("busy_mid_flight", int'(bsy[0]), 1);
        ce[0] = 1'b1; il[0] = 16'sd999; ir[0] = 16'sd999; ena[0] = 2'b00;
        @(negedge clk);
        ce[0] = 1'b0; il[0] = '0; ir[0] = '0;
        check("overrun_set", int'(ovr[0]), 1);
        drain("overrun");
        repeat (40) @(negedge clk);
        check("overrun_pulses", pulse_cnt[0] - p0, 1);
        check("overrun_sticky", int'(ovr[0]), 1);

        // Reset at cycle 8 abandons the sample and clears history.
        p0 = pulse_cnt[0];
        send(0, 2'b11, 5000, 5000, 1'b0, 0, 0, 0);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("reset_pulses", pulse_cnt[0] - p0, 0);
        check("reset_overrun", int'(ovr[0]), 0);
        check("reset_busy", int'(bsy[0]), 0);
        check("reset_out_l", int'(ol[0]), 0);
        send(0, 2'b11, 16384, 0, 1'b1, 16384, 0, 26);
        drain("fresh0");
        send(0, 2'b11, 0, 0, 1'b1, 16383, 0, 26);
        drain("fresh1");

        // Two equal samples through b0 = b1 = unity give gain 2 on the second.
        p2 = pulse_cnt[2];
        send(2, 2'b01, 30000, -30000, 1'b1, 30000, -30000, 14);
        drain("gain0");
`ifdef AUDIO_FILTER_SAT_EN
        send(2, 2'b01, 30000, -30000, 1'b1, 32767, -32768, 14);
`else
        send(2, 2'b01, 30000, -30000, 1'b1, -5536, 5536, 14);
`endif
        drain("gain1");
        check("gain_pulses", pulse_cnt[2] - p2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
